hiscore_upload: RTL and testbench

Streams a contiguous window of game work RAM out to the host through the data_io upload path (ioctl_upload / ioctl_rd / ioctl_din), so that high-score tables can be saved to SD card. It is the read-side counterpart of the ROM download path. It sits in the core top level between data_io and the game RAM arbiter. It holds the game CPU paused while the upload runs and fetches bytes over a toggle req/ack handshake.

---
 rtl/hiscore_pkg.sv | 19 +
 rtl/hiscore_upload.sv | 156 +++++++++++++++
 tb/tb_hiscore_upload.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hiscore_pkg.sv
// Purpose: shared types and constants for the high-score upload block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package hiscore_pkg;

    // Upload sequencer states.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        FETCH  = 3'd2,
        WAIT   = 3'd3,
        READY  = 3'd4,
        DRAIN  = 3'd5
    } state_t;

    // Byte returned once the host reads past the end of the window.
    localparam logic [7:0] OVER_READ_BYTE = 8'h00;

endpackage

// File: rtl/hiscore_upload.sv
// Purpose: stream a window of game work RAM to the host over the ioctl upload path, CPU paused.
// Latency: first RAM request PAUSE_CYCLES+2 cycles after session start; byte ready 2 cycles + RAM latency after ioctl_rd.
// Backpressure: host paces with ioctl_rd; one early read is remembered; a RAM request in flight is always drained.
module hiscore_upload
    import hiscore_pkg::*;
#(
    parameter int         ADDR_W       = 10,
    parameter int         BASE         = 0,
    parameter int         LEN          = 64,
    parameter logic [7:0] INDEX        = 8'd3,
    parameter int         PAUSE_CYCLES = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    output logic [7:0]        ioctl_din,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_req,
    input  logic              ram_ack,
    input  logic [7:0]        ram_q,
    output logic              pause_cpu,
    output logic              busy
);

    localparam int CNT_W = $clog2(PAUSE_CYCLES + 1);

    // ptr needs one extra bit so that LEN == 2^ADDR_W is representable.
    localparam logic [ADDR_W:0]   LEN_P    = (ADDR_W + 1)'(LEN);
    localparam logic [ADDR_W:0]   PTR_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PAUSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    state_t            state, state_n;
    logic [ADDR_W:0]   ptr, ptr_n;
    logic [CNT_W-1:0]  settle_cnt, settle_cnt_n;
    logic              pending, pending_n;
    logic [7:0]        din_n;
    logic [ADDR_W-1:0] addr_n;
    logic              req_n;
    logic              active;
    logic              ack_match;

    assign active    = ioctl_upload && (ioctl_index == INDEX);
    assign ack_match = (ram_ack == ram_req);

    // Next-state and next-output computation for the upload sequencer.
    always_comb begin
        state_n      = state;
        ptr_n        = ptr;
        settle_cnt_n = settle_cnt;
        pending_n    = pending;
        din_n        = ioctl_din;
        addr_n       = ram_addr;
        req_n        = ram_req;

        case (state)
            IDLE: begin
                pending_n = 1'b0;
                if (active) begin
                    state_n      = SETTLE;
                    ptr_n        = '0;
                    settle_cnt_n = '0;
                end
            end

            SETTLE: begin
                if (!active) begin
                    state_n = IDLE;
                end else if (settle_cnt == CNT_LAST) begin
                    state_n = FETCH;
                end else begin
                    settle_cnt_n = settle_cnt + CNT_ONE;
                end
            end

            FETCH: begin
                if (ioctl_rd) begin
                    pending_n = 1'b1;
                end
                if (ptr < LEN_P) begin
                    // Once the request toggles it must be drained, even if the host has left.
                    addr_n  = BASE_A + ptr[ADDR_W-1:0];
                    req_n   = ~ram_req;
                    state_n = active ? WAIT : DRAIN;
                end else if (active) begin
                    din_n   = OVER_READ_BYTE;
                    state_n = READY;
                end else begin
                    state_n = IDLE;
                end
            end

            WAIT: begin
                if (ioctl_rd) begin
                    pending_n = 1'b1;
                end
                if (!active) begin
                    state_n = DRAIN;
                end else if (ack_match) begin
                    din_n   = ram_q;
                    state_n = READY;
                end
            end

            READY: begin
                if (!active) begin
                    state_n = IDLE;
                end else if (ioctl_rd || pending) begin
                    // A read that arrived while fetching is honoured here; ptr parks at LEN.
                    pending_n = 1'b0;
                    ptr_n     = (ptr < LEN_P) ? (ptr + PTR_ONE) : ptr;
                    state_n   = FETCH;
                end
            end

            DRAIN: begin
                if (ack_match) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered outputs; pause/busy follow the state being entered.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= '0;
            settle_cnt <= '0;
            pending    <= 1'b0;
            ioctl_din  <= 8'h00;
            ram_addr   <= '0;
            ram_req    <= 1'b0;
            pause_cpu  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            ptr        <= ptr_n;
            settle_cnt <= settle_cnt_n;
            pending    <= pending_n;
            ioctl_din  <= din_n;
            ram_addr   <= addr_n;
            ram_req    <= req_n;
            pause_cpu  <= (state_n != IDLE);
            busy       <= (state_n != IDLE);
        end
    end

endmodule

// File: tb/tb_hiscore_upload.sv
// Purpose: directed bench for hiscore_upload with two instances (normal window and wrapping over-read window).
// Latency: checks first-request timing and per-byte delivery against a byte-window model.
// Backpressure: host rd pulses paced by the bench; RAM responder with programmable latency.
module tb_hiscore_upload;

    localparam int P = 16;

    logic            clk_sys = 1'b0;
    logic            reset_n;
    logic            ioctl_upload;
    logic [7:0]      ioctl_index;
    logic            ioctl_rd;
    logic [1:0][7:0] din;
    logic [1:0][9:0] raddr;
    logic [1:0]      req;
    logic [1:0]      ack;
    logic [1:0][7:0] q;
    logic [1:0]      pause;
    logic [1:0]      busy;

    logic [7:0] ram [1024];
    int  base_of [2] = '{256, 1023};
    int  len_of  [2] = '{4, 2};
    int  lat = 3;
    int  fetch_cnt [2] = '{0, 0};
    int  first_tog_cyc [2] = '{0, 0};
    logic [1:0] req_prev = 2'b00;
    logic [1:0] req_seen;
    int  rcnt [2];
    int  cyc = 0;
    int  rise_cyc = 0;
    int  errors = 0;
    int  checks = 0;

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    hiscore_upload #(.ADDR_W(10), .BASE(256), .LEN(4), .INDEX(8'd3), .PAUSE_CYCLES(P)) u_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_din(din[0]),
        .ram_addr(raddr[0]), .ram_req(req[0]), .ram_ack(ack[0]), .ram_q(q[0]),
        .pause_cpu(pause[0]), .busy(busy[0])
    );

    hiscore_upload #(.ADDR_W(10), .BASE(1023), .LEN(2), .INDEX(8'd5), .PAUSE_CYCLES(P)) u_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_upload(ioctl_upload),
        .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_din(din[1]),
        .ram_addr(raddr[1]), .ram_req(req[1]), .ram_ack(ack[1]), .ram_q(q[1]),
        .pause_cpu(pause[1]), .busy(busy[1])
    );

    // Behavioural RAM responders: acknowledge each request toggle after 'lat' cycles.
    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ack      <= 2'b00;
            q        <= '0;
            req_seen <= 2'b00;
            rcnt[0]  <= 0;
            rcnt[1]  <= 0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (req[i] != req_seen[i]) begin
                    req_seen[i] <= req[i];
                    rcnt[i]     <= lat;
                end else if (rcnt[i] > 0) begin
                    rcnt[i] <= rcnt[i] - 1;
                    if (rcnt[i] == 1) begin
                        ack[i] <= req[i];
                        q[i]   <= ram[raddr[i]];
                    end
                end
            end
        end
    end

    // Model: byte k of a session is the k-th byte of the window, or 00 past its end.
    function automatic logic [7:0] exp_byte(input int d, input int k);
        if (k < len_of[d]) return ram[(base_of[d] + k) % 1024];
        return 8'h00;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic pulse_rd();
        ioctl_rd = 1'b1;
        cycles(1);
        ioctl_rd = 1'b0;
    endtask

    task automatic start(input logic [7:0] idx);
        fetch_cnt[0] = 0;
        fetch_cnt[1] = 0;
        ioctl_index  = idx;
        ioctl_upload = 1'b1;
        rise_cyc     = cyc;
    endtask

    // Per-cycle compare: every request goes to the next window address, never past LEN,
    // and an idle block never leaves a request outstanding.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                fetch_cnt[0] = 0;
                fetch_cnt[1] = 0;
                req_prev     = req;
            end else begin
                for (int i = 0; i < 2; i++) begin
                    if (!busy[i]) chk("rest_handshake", {31'd0, ack[i]}, {31'd0, req[i]});
                    if (req[i] != req_prev[i]) begin
                        if (fetch_cnt[i] == 0) first_tog_cyc[i] = cyc;
                        chk("fetch_addr", {22'd0, raddr[i]}, (base_of[i] + fetch_cnt[i]) % 1024);
                        chk("fetch_in_range", {31'd0, fetch_cnt[i] < len_of[i]}, 32'd1);
                        fetch_cnt[i] = fetch_cnt[i] + 1;
                    end
                    req_prev[i] = req[i];
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit_a [4];
        logic [7:0] got [6];
        int n;
        lit_a = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 1);
        ram[256] = 8'hAA; ram[257] = 8'hBB; ram[258] = 8'hCC; ram[259] = 8'hDD;
        ram[1023] = 8'h5A; ram[0] = 8'hC3;

        reset_n = 1'b0; ioctl_upload = 1'b0; ioctl_index = 8'd0; ioctl_rd = 1'b0;
        cycles(3);
        for (int i = 0; i < 2; i++) begin
            chk("reset_din", {24'd0, din[i]}, 32'd0);
            chk("reset_addr", {22'd0, raddr[i]}, 32'd0);
            chk("reset_req", {31'd0, req[i]}, 32'd0);
            chk("reset_pause", {31'd0, pause[i]}, 32'd0);
            chk("reset_busy", {31'd0, busy[i]}, 32'd0);
        end
        reset_n = 1'b1;
        cycles(2);

        // Normal upload, latency 3.
        lat = 3;
        start(8'd3);
        chk("pause_before", {31'd0, pause[0]}, 32'd0);
        cycles(1);
        chk("pause_after_rise", {31'd0, pause[0]}, 32'd1);
        chk("busy_after_rise", {31'd0, busy[0]}, 32'd1);
        chk("other_idle", {31'd0, busy[1]}, 32'd0);
        cycles(63);
        for (int k = 0; k < 4; k++) begin
            chk("normal_byte", {24'd0, din[0]}, {24'd0, lit_a[k]});
            pulse_rd();
            cycles(63);
        end
        chk("first_toggle_delay", first_tog_cyc[0] - rise_cyc, P + 2);
        chk("normal_fetch_count", fetch_cnt[0], 32'd4);
        ioctl_upload = 1'b0;
        cycles(1);
        chk("normal_pause_drop", {31'd0, pause[0]}, 32'd0);
        chk("normal_busy_drop", {31'd0, busy[0]}, 32'd0);
        cycles(2);

        // Index mismatch.
        start(8'd0);
        cycles(40);
        for (int i = 0; i < 2; i++) begin
            chk("mismatch_busy", {31'd0, busy[i]}, 32'd0);
            chk("mismatch_pause", {31'd0, pause[i]}, 32'd0);
            chk("mismatch_fetches", fetch_cnt[i], 32'd0);
        end
        ioctl_upload = 1'b0;
        cycles(2);

        // Over-read on the wrapping two-byte window.
        start(8'd5);
        cycles(64);
        for (int k = 0; k < 5; k++) begin
            got[k] = din[1];
            chk("overread_byte", {24'd0, din[1]}, {24'd0, exp_byte(1, k)});
            pulse_rd();
            cycles(63);
        end
        got[5] = din[1];
        chk("overread_byte", {24'd0, din[1]}, {24'd0, exp_byte(1, 5)});
        chk("overread_b0", {24'd0, got[0]}, 32'h5A);
        chk("overread_b1", {24'd0, got[1]}, 32'hC3);
        for (int k = 2; k < 6; k++) chk("overread_zero", {24'd0, got[k]}, 32'h00);
        chk("overread_fetches", fetch_cnt[1], 32'd2);
        ioctl_upload = 1'b0;
        cycles(3);

        // Early rd during WAIT, latency 20.
        lat = 20;
        start(8'd3);
        cycles(64);
        chk("early_b0", {24'd0, din[0]}, 32'hAA);
        pulse_rd();
        cycles(4);
        pulse_rd();
        cycles(63);
        chk("early_b2", {24'd0, din[0]}, {24'd0, exp_byte(0, 2)});
        chk("early_fetches3", fetch_cnt[0], 32'd3);
        pulse_rd();
        cycles(63);
        chk("early_b3", {24'd0, din[0]}, 32'hDD);
        chk("early_fetches4", fetch_cnt[0], 32'd4);
        ioctl_upload = 1'b0;
        cycles(3);

        // Abort mid-WAIT: drain the outstanding request, then idle.
        start(8'd3);
        cycles(64);
        chk("abort_b0", {24'd0, din[0]}, 32'hAA);
        pulse_rd();
        cycles(4);
        ioctl_upload = 1'b0;
        cycles(1);
        chk("abort_draining", {31'd0, busy[0]}, 32'd1);
        chk("abort_outstanding", {31'd0, req[0] ^ ack[0]}, 32'd1);
        n = 0;
        while (busy[0] && n < 100) begin
            cycles(1);
            n++;
        end
        chk("abort_drain_done", {31'd0, busy[0]}, 32'd0);
        chk("abort_drain_len", n, 32'd18);
        chk("abort_req_eq_ack", {31'd0, req[0]}, {31'd0, ack[0]});
        chk("abort_din_held", {24'd0, din[0]}, 32'hAA);
        chk("abort_pause", {31'd0, pause[0]}, 32'd0);
        cycles(3);

        // Reset mid-fetch, then a fresh upload from the start of the window.
        start(8'd3);
        cycles(64);
        pulse_rd();
        cycles(4);
        reset_n = 1'b0;
        #1;
        chk("rst_din", {24'd0, din[0]}, 32'd0);
        chk("rst_addr", {22'd0, raddr[0]}, 32'd0);
        chk("rst_req", {31'd0, req[0]}, 32'd0);
        chk("rst_pause", {31'd0, pause[0]}, 32'd0);
        chk("rst_busy", {31'd0, busy[0]}, 32'd0);
        cycles(2);
        reset_n = 1'b1;
        rise_cyc = cyc;
        cycles(64);
        chk("rst_fresh_b0", {24'd0, din[0]}, 32'hAA);
        chk("rst_fresh_fetches", fetch_cnt[0], 32'd1);
        chk("rst_first_toggle", first_tog_cyc[0] - rise_cyc, P + 2);
        ioctl_upload = 1'b0;
        cycles(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
